ym_bus_seq: RTL
===============

# ym_bus_seq

Host-side access sequencer that drives the YM3812 (OPL2) parallel bus. It accepts single register read/write requests from the card's host-bus decode logic and generates `ym_cs_l`/`ym_a0`/`ym_wr_l`/`ym_rd_l` strobes with programmable setup, strobe and hold widths. It drives or tri-states `yd` and returns read data. It enforces the chip's post-write recovery time so firmware and host software never overrun the OPL2.

## Interface
Parameters:
- `SETUP_CYC`, 1: cycles `ym_cs_l`/`ym_a0` (and `yd` on writes) are valid before the strobe; range 1..15.
- `STROBE_CYC`, 4: cycles `ym_wr_l`/`ym_rd_l` held low; range 1..15.
- `HOLD_CYC`, 1: cycles `ym_cs_l`/`ym_a0`/`yd` held after the strobe rises; range 1..15.
- `ADDR_WAIT_CYC`, 66: recovery after an a0=0 (address) write; 3.3 µs at 20 MHz; range 0..1023.
- `DATA_WAIT_CYC`, 460: recovery after an a0=1 (data) write; 23 µs at 20 MHz; range 0..1023.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous reset, active-high.
- `req` in 1: start an access; accepted only when `busy`=0.
- `req_rd` in 1: 1=read, 0=write.
- `req_a0` in 1: value for `ym_a0`.
- `req_wdata` in 8: write data.
- `busy` out 1: high from the accept edge until the sequence, including recovery, completes.
- `rdata` out 8: last read data, held until the next read completes.
- `rdata_valid` out 1: one-cycle pulse when `rdata` updates.
- `yd` inout 8: YM3812 data bus.
- `ym_cs_l` out 1: chip select, active-low.
- `ym_a0` out 1: address/data select.
- `ym_wr_l` out 1: write strobe, active-low.
- `ym_rd_l` out 1: read strobe, active-low.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. All bus outputs are registered.
- **IDLE:** `busy`=0.
  - A `req` sampled high latches `req_rd`, `req_a0` and `req_wdata`.
  - On that edge: `ym_cs_l`=0, `ym_a0`=latched value, `busy`=1. For writes only, the `yd` driver is enabled with the latched data.
  - Next state: SETUP.
- **SETUP:** lasts `SETUP_CYC` cycles, then asserts `ym_wr_l`=0 (write) or `ym_rd_l`=0 (read) and goes to STROBE.
- **STROBE:** lasts `STROBE_CYC` cycles.
  - For reads, `yd` is sampled on the edge that ends STROBE; that same edge loads `rdata` and pulses `rdata_valid`.
  - On exit the strobe is deasserted and the FSM goes to HOLD.
- **HOLD:** lasts `HOLD_CYC` cycles.
  - On exit: `ym_cs_l`=1 and `yd` is released to Z. `ym_a0` keeps its value.
  - Write: go to RECOVER, loading the wait counter with `DATA_WAIT_CYC` if a0=1, else `ADDR_WAIT_CYC`.
  - Read: go to IDLE.
- **RECOVER:** the counter decrements each cycle; at 0 the FSM goes to IDLE. A wait value of 0 goes straight to IDLE.
- `req` while `busy`=1 is ignored. There is no queue, and the host decode stretches its cycle on `busy`.
- `yd` is never driven during a read, nor while `ym_cs_l`=1.
- **Reset**, at any point including mid-strobe: the next edge forces
  - `ym_cs_l`=1, `ym_wr_l`=1, `ym_rd_l`=1, `ym_a0`=0;
  - `yd`=Z, `busy`=0, `rdata`=0x00, `rdata_valid`=0;
  - state IDLE, counter 0.
  
  An access aborted by reset produces no `rdata_valid`.

## Timing
- Accept edge = E.
- `ym_cs_l` falls at E.
- The strobe falls at E+`SETUP_CYC`.
- The strobe rises at E+`SETUP_CYC`+`STROBE_CYC`. For reads, `rdata_valid` is high in the cycle that follows this edge.
- `ym_cs_l` rises at E+`SETUP_CYC`+`STROBE_CYC`+`HOLD_CYC`.
- Read: `busy` falls at the same edge as `ym_cs_l` rises.
- Write: `busy` falls `WAIT` cycles after `ym_cs_l` rises.
- A `req` held high during the cycle `busy` falls is accepted on the next edge. Minimum gap between accesses with `busy` low is 1 cycle.

## Configuration
- `YM_RECOVERY_WAIT_EN` defined: RECOVER state and wait counter present, as above.
- Not defined: RECOVER is omitted. Writes return to IDLE at HOLD exit like reads, and the `*_WAIT_CYC` parameters are unused. For hosts that poll the OPL2 timing in software.

## Structure
- Package `ym_bus_pkg`:
  - state enum `ym_seq_state_t`;
  - default cycle constants;
  - `YM_WAIT_W`=10 counter width.
- Sub-module `ym_wait_timer`: 10-bit loadable down-counter with load, value and `done` output. It serves SETUP, STROBE, HOLD and RECOVER, reloaded at each state entry.

## Test plan
Bench defaults apply unless stated. The bus model returns 0xAA when a0=1 and 0x55 when a0=0.
- **Write, a0=0, data 0xBD** → `ym_cs_l` low 6 cycles; `ym_wr_l` low exactly 4 cycles starting E+1; `yd`=0xBD throughout `ym_cs_l` low, then Z; `busy` high 72 cycles total.
- **Write, a0=1** → `busy` high 6+460=466 cycles. A second `req` issued mid-recovery is ignored; a new `req` at the `busy` fall edge starts at the next edge.
- **Read, a0=1, then read, a0=0** → `rdata`=0xAA then 0x55; each with a one-cycle `rdata_valid`; `ym_rd_l` low 4 cycles; `yd` never driven by the block; `busy` 6 cycles each.
- **Reset asserted during STROBE of a read** → next edge all strobes high, `yd`=Z, `busy`=0, `rdata`=0x00, no `rdata_valid`; a subsequent write completes normally.
- **`YM_RECOVERY_WAIT_EN` undefined, a0=1 write** → `busy` high 6 cycles.
- **`SETUP_CYC`=`STROBE_CYC`=`HOLD_CYC`=1, `ADDR_WAIT_CYC`=0** → an a0=0 write keeps `busy` high 3 cycles.

Source files
------------

// File: rtl/ym_bus_pkg.sv
// Shared types and constants for the YM3812 (OPL2) bus sequencer.
// Holds the FSM state enum, default cycle counts and the wait-counter width.
package ym_bus_pkg;

    localparam int YM_WAIT_W = 10;

    localparam int YM_SETUP_CYC_DEF     = 1;
    localparam int YM_STROBE_CYC_DEF    = 4;
    localparam int YM_HOLD_CYC_DEF      = 1;
    localparam int YM_ADDR_WAIT_CYC_DEF = 66;
    localparam int YM_DATA_WAIT_CYC_DEF = 460;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } ym_seq_state_t;

    // The timer exits a phase when it reaches zero, so an N-cycle phase loads N-1.
    function automatic logic [YM_WAIT_W-1:0] ym_cyc_minus1(input logic [YM_WAIT_W-1:0] cyc);
        return (cyc == '0) ? '0 : cyc - 1'b1;
    endfunction

endpackage

// File: rtl/ym_wait_timer.sv
// Loadable 10-bit down-counter that times every phase of a bus access.
// It stops at zero and reports done while its value is zero.
module ym_wait_timer
    import ym_bus_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [YM_WAIT_W-1:0] load_value,
    output logic [YM_WAIT_W-1:0] value,
    output logic                 done
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign done = (value == '0);

endmodule

// File: rtl/ym_bus_seq.sv
// Host-side YM3812 access sequencer: timed cs/a0/wr/rd strobes, yd drive and read capture.
// Define YM_RECOVERY_WAIT_EN to include the post-write RECOVER state and its wait.
module ym_bus_seq
    import ym_bus_pkg::*;
#(
    parameter int SETUP_CYC     = YM_SETUP_CYC_DEF,
    parameter int STROBE_CYC    = YM_STROBE_CYC_DEF,
    parameter int HOLD_CYC      = YM_HOLD_CYC_DEF,
    parameter int ADDR_WAIT_CYC = YM_ADDR_WAIT_CYC_DEF,
    parameter int DATA_WAIT_CYC = YM_DATA_WAIT_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       req_rd,
    input  logic       req_a0,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    inout  wire  [7:0] yd,
    output logic       ym_cs_l,
    output logic       ym_a0,
    output logic       ym_wr_l,
    output logic       ym_rd_l
);

`ifdef YM_RECOVERY_WAIT_EN
    localparam bit RECOVERY_EN = 1'b1;
`else
    localparam bit RECOVERY_EN = 1'b0;
`endif

    localparam logic [YM_WAIT_W-1:0] SETUP_W  = YM_WAIT_W'(SETUP_CYC);
    localparam logic [YM_WAIT_W-1:0] STROBE_W = YM_WAIT_W'(STROBE_CYC);
    localparam logic [YM_WAIT_W-1:0] HOLD_W   = YM_WAIT_W'(HOLD_CYC);
    localparam logic [YM_WAIT_W-1:0] ADDR_W   = YM_WAIT_W'(ADDR_WAIT_CYC);
    localparam logic [YM_WAIT_W-1:0] DATA_W   = YM_WAIT_W'(DATA_WAIT_CYC);

    ym_seq_state_t        state;
    logic                 is_rd;
    logic                 drive_en;
    logic [7:0]           wdata_q;
    logic                 timer_load;
    logic [YM_WAIT_W-1:0] timer_init;
    logic [YM_WAIT_W-1:0] timer_count;
    logic                 timer_done;
    logic [YM_WAIT_W-1:0] wait_cyc;
    logic                 wait_needed;

    assign wait_cyc    = ym_a0 ? DATA_W : ADDR_W;
    assign wait_needed = RECOVERY_EN && !is_rd && (wait_cyc != '0);

    assign yd = drive_en ? wdata_q : 8'bzzzz_zzzz;

    ym_wait_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_init),
        .value      (timer_count),
        .done       (timer_done)
    );

    // The timer is reloaded on the same edge the FSM enters the next phase.
    always_comb begin
        timer_load = 1'b0;
        timer_init = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    timer_load = 1'b1;
                    timer_init = ym_cyc_minus1(SETUP_W);
                end
            end
            SETUP: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_init = ym_cyc_minus1(STROBE_W);
                end
            end
            STROBE: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_init = ym_cyc_minus1(HOLD_W);
                end
            end
            HOLD: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_init = ym_cyc_minus1(wait_cyc);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            is_rd       <= 1'b0;
            drive_en    <= 1'b0;
            wdata_q     <= 8'h00;
            busy        <= 1'b0;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            ym_cs_l     <= 1'b1;
            ym_a0       <= 1'b0;
            ym_wr_l     <= 1'b1;
            ym_rd_l     <= 1'b1;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        is_rd    <= req_rd;
                        ym_a0    <= req_a0;
                        wdata_q  <= req_wdata;
                        drive_en <= !req_rd;
                        ym_cs_l  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer_done) begin
                        if (is_rd) begin
                            ym_rd_l <= 1'b0;
                        end else begin
                            ym_wr_l <= 1'b0;
                        end
                        state <= STROBE;
                    end
                end
                STROBE: begin
                    if (timer_done) begin
                        ym_wr_l <= 1'b1;
                        ym_rd_l <= 1'b1;
                        if (is_rd) begin
                            rdata       <= yd;
                            rdata_valid <= 1'b1;
                        end
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (timer_done) begin
                        ym_cs_l  <= 1'b1;
                        drive_en <= 1'b0;
                        if (wait_needed) begin
                            state <= RECOVER;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                RECOVER: begin
                    if (timer_count == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
